// File: rtl/producer_arbiter.sv
// Round-robin arbiter sharing the GALS buffer write port between the Fibonacci
// and timer producers, with burst limiting, a one-word skid and stop/drain.
module producer_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_f,
    input  logic                  req_t,
    input  logic                  f_valid,
    input  logic [DATA_WIDTH-1:0] f_out,
    input  logic                  t_valid,
    input  logic [DATA_WIDTH-1:0] t_out,
    input  logic                  stop,
    input  logic                  buffer_full,
    input  logic                  buffer_empty,
    input  logic                  data_2_valid,
    output logic                  f_en,
    output logic                  t_en,
    output logic                  data_1_en,
    output logic [DATA_WIDTH-1:0] data_1,
    output logic [1:0]            owner,
    output logic [4:0]            state_led
);

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        GRANT_F = 5'b00010,
        GRANT_T = 5'b00100,
        SWITCH  = 5'b01000,
        DRAIN   = 5'b10000
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

    state_t                  state;
    state_t                  state_nxt;
    logic                    last_t;
    logic [3:0]              burst_cnt;
    logic [3:0]              cnt_inc;
    logic                    skid_full;
    logic [DATA_WIDTH-1:0]   skid_data;

    logic                    grant_f;
    logic                    grant_t;
    logic                    acc;
    logic                    skid_out;
    logic                    direct;
    logic                    to_skid;
    logic                    burst_done;
    logic                    end_burst;
    logic [DATA_WIDTH-1:0]   word_p0;

    // Tie goes to whichever producer was not served last.
    function automatic state_t arbitrate(input logic rf, input logic rt, input logic lt);
        state_t s;
        s = IDLE;
        if (rf && rt)
            s = lt ? GRANT_F : GRANT_T;
        else if (rf)
            s = GRANT_F;
        else if (rt)
            s = GRANT_T;
        return s;
    endfunction

    always_comb begin
        grant_f  = (state == GRANT_F);
        grant_t  = (state == GRANT_T);
        acc      = (grant_f && f_valid) || (grant_t && t_valid);
        word_p0  = grant_f ? f_out : t_out;
        // Skid drains first; a word arriving alongside it takes its place.
        skid_out = skid_full && !buffer_full;
        direct   = acc && !buffer_full && !skid_full;
        to_skid  = acc && !direct && !(skid_full && buffer_full);
        cnt_inc  = (acc && (burst_cnt != BURST_MAX)) ? burst_cnt + 4'd1 : burst_cnt;
        burst_done = (cnt_inc == BURST_MAX) || (grant_f ? !req_f : !req_t);
    end

    always_comb begin
        state_nxt = state;
        end_burst = 1'b0;
        case (state)
            IDLE: state_nxt = arbitrate(req_f, req_t, last_t);
            GRANT_F, GRANT_T: begin
                if (stop) begin
                    state_nxt = DRAIN;
                end else if (burst_done) begin
                    state_nxt = SWITCH;
                    end_burst = 1'b1;
                end
            end
            SWITCH: state_nxt = stop ? DRAIN : arbitrate(req_f, req_t, last_t);
            DRAIN: begin
                if (!skid_full && buffer_empty && !data_2_valid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        f_en      = grant_f && !buffer_full && !skid_full;
        t_en      = grant_t && !buffer_full && !skid_full;
        owner     = {grant_t, grant_f};
        state_led = state;
    end

    // Stage p0 -> output register: one word per cycle onto data_1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_t    <= 1'b1;
            burst_cnt <= 4'd0;
            skid_full <= 1'b0;
            skid_data <= '0;
            data_1    <= '0;
            data_1_en <= 1'b0;
        end else begin
            state     <= state_nxt;
            if (end_burst)
                last_t <= grant_t;
            burst_cnt <= ((grant_f || grant_t) && (state_nxt == state)) ? cnt_inc : 4'd0;
            data_1_en <= skid_out || direct;
            if (skid_out)
                data_1 <= skid_data;
            else if (direct)
                data_1 <= word_p0;
            if (to_skid) begin
                skid_full <= 1'b1;
                skid_data <= word_p0;
            end else if (skid_out) begin
                skid_full <= 1'b0;
            end
        end
    end

endmodule
